smc_step_sequencer: RTL

SMC_STEP_SEQUENCER -- requirements
Module: smc_step_sequencer

---
 rtl/smc_step_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/smc_step_sequencer.sv
// smc_step_sequencer: register-programmed stepper motor coil sequencer.
//
// A small register bank (CTRL, PERIOD, STEPS, STATUS) programs a step engine
// that walks a coil phase table forward or backward, one phase every PERIOD
// clock cycles, for STEPS steps. Coils are driven through separate high-side
// (MNP) and low-side (MNM) enables.
//
// Build option:
//   SMC_SEQ_HALFSTEP_EN  defined   -> 8-phase half-step table
//                        undefined -> 4-phase full-step table (default)
//
// Ports:
//   QCLK      in   1   clock, rising edge
//   QRESET    in   1   asynchronous reset, active low
//   QSEL      in   1   register access select
//   QWRITE    in   1   1 = write, 0 = read (qualified by QSEL)
//   QADDR     in   7   register byte offset
//   QDATAIN   in  16   write data
//   QDATAOUT  out 16   read data (combinational, 0 unless a read is selected)
//   MNP       out  2   high-side drive, bit0 = coil A, bit1 = coil B
//   MNM       out  2   low-side drive,  bit0 = coil A, bit1 = coil B
//   IRQ       out  1   level interrupt = STATUS.DONE & CTRL.IRQ_EN
module smc_step_sequencer (
  input  logic        QCLK,
  input  logic        QRESET,
  input  logic        QSEL,
  input  logic        QWRITE,
  input  logic [6:0]  QADDR,
  input  logic [15:0] QDATAIN,
  output logic [15:0] QDATAOUT,
  output logic [1:0]  MNP,
  output logic [1:0]  MNM,
  output logic        IRQ
);

  localparam logic [6:0] AddrCtrl   = 7'h00;
  localparam logic [6:0] AddrPeriod = 7'h02;
  localparam logic [6:0] AddrSteps  = 7'h04;
  localparam logic [6:0] AddrStatus = 7'h06;

`ifdef SMC_SEQ_HALFSTEP_EN
  localparam logic [2:0] PhaseMax = 3'd7;
`else
  localparam logic [2:0] PhaseMax = 3'd3;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        dir_q, dir_d;
  logic        irq_en_q, irq_en_d;
  logic        hold_q, hold_d;
  logic [15:0] period_q, period_d;
  logic [15:0] steps_q, steps_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  phase_q, phase_d;
  logic        done_q, done_d;

  // Register access decode
  logic wr_en;
  logic wr_ctrl, wr_period, wr_steps, wr_status;
  logic go_req, stop_req;

  assign wr_en     = QSEL & QWRITE;
  assign wr_ctrl   = wr_en && (QADDR == AddrCtrl);
  assign wr_period = wr_en && (QADDR == AddrPeriod);
  assign wr_steps  = wr_en && (QADDR == AddrSteps);
  assign wr_status = wr_en && (QADDR == AddrStatus);

  // STOP dominates GO when both are written together.
  assign stop_req = wr_ctrl & QDATAIN[2];
  assign go_req   = wr_ctrl & QDATAIN[0] & ~QDATAIN[2];

  // A programmed period of 0 behaves as 1 cycle per step.
  logic [15:0] period_eff;
  assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;

  // Neighbouring phases with wrap-around at the table ends.
  logic [2:0] phase_fwd, phase_rev, phase_step;
  assign phase_fwd  = (phase_q == PhaseMax) ? 3'd0 : phase_q + 3'd1;
  assign phase_rev  = (phase_q == 3'd0) ? PhaseMax : phase_q - 3'd1;
  assign phase_step = dir_q ? phase_rev : phase_fwd;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    irq_en_d = irq_en_q;
    hold_d   = hold_q;
    period_d = period_q;
    steps_d  = steps_q;
    timer_d  = timer_q;
    phase_d  = phase_q;
    done_d   = done_q;

    if (wr_ctrl) begin
      dir_d    = QDATAIN[1];
      irq_en_d = QDATAIN[3];
      hold_d   = QDATAIN[4];
    end

    // New PERIOD is only sampled at the next timer reload.
    if (wr_period) begin
      period_d = QDATAIN;
    end

    if (wr_steps && (state_q != StRun)) begin
      steps_d = QDATAIN;
    end

    // Clear is evaluated before the FSM so a same-cycle DONE entry wins.
    if (wr_status && QDATAIN[1]) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // A GO landing in the single DONE cycle is dropped; only IDLE starts.
        if (go_req) begin
          if (steps_q != 16'd0) begin
            state_d = StRun;
            timer_d = period_eff;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StRun: begin
        if (stop_req) begin
          // Abort keeps phase and remaining step count intact.
          state_d = StIdle;
        end else if (timer_q <= 16'd1) begin
          phase_d = phase_step;
          steps_d = steps_q - 16'd1;
          timer_d = period_eff;
          if (steps_q == 16'd1) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers
  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      irq_en_q <= 1'b0;
      hold_q   <= 1'b0;
      period_q <= 16'd1;
      steps_q  <= 16'd0;
      timer_q  <= 16'd0;
      phase_q  <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      irq_en_q <= irq_en_d;
      hold_q   <= hold_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      timer_q  <= timer_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
    end
  end

  // Coil pattern lookup: returns {MNP[1:0], MNM[1:0]}. A coil is either driven
  // positive (MNP=1), negative (MNM=1) or off, never both sides at once.
  function automatic logic [3:0] phase_pattern(input logic [2:0] ph);
    logic [3:0] pat;
`ifdef SMC_SEQ_HALFSTEP_EN
    case (ph)
      3'd0:    pat = 4'b01_00;  // A+ , B0
      3'd1:    pat = 4'b11_00;  // A+ , B+
      3'd2:    pat = 4'b10_00;  // A0 , B+
      3'd3:    pat = 4'b10_01;  // A- , B+
      3'd4:    pat = 4'b00_01;  // A- , B0
      3'd5:    pat = 4'b00_11;  // A- , B-
      3'd6:    pat = 4'b00_10;  // A0 , B-
      3'd7:    pat = 4'b01_10;  // A+ , B-
      default: pat = 4'b00_00;
    endcase
`else
    case (ph[1:0])
      2'd0:    pat = 4'b11_00;  // A+ , B+
      2'd1:    pat = 4'b10_01;  // A- , B+
      2'd2:    pat = 4'b00_11;  // A- , B-
      2'd3:    pat = 4'b01_10;  // A+ , B-
      default: pat = 4'b00_00;
    endcase
`endif
    return pat;
  endfunction

  // Coil drive: always active while running, otherwise only when holding.
  logic       drive_en;
  logic [3:0] pattern;

  assign drive_en = (state_q == StRun) | hold_q;
  assign pattern  = phase_pattern(phase_q);

  always_comb begin
    MNP = 2'b00;
    MNM = 2'b00;
    if (drive_en) begin
      MNP = pattern[3:2];
      MNM = pattern[1:0];
    end
  end

  assign IRQ = done_q & irq_en_q;

  // Read mux
  always_comb begin
    QDATAOUT = 16'd0;
    if (QSEL && !QWRITE) begin
      case (QADDR)
        AddrCtrl:   QDATAOUT = {11'd0, hold_q, irq_en_q, 1'b0, dir_q, 1'b0};
        AddrPeriod: QDATAOUT = period_q;
        AddrSteps:  QDATAOUT = steps_q;
        AddrStatus: QDATAOUT = {11'd0, phase_q, done_q, (state_q == StRun)};
        default:    QDATAOUT = 16'd0;
      endcase
    end
  end

endmodule
